// File: rtl/seg7_capture.sv
// Multiplexed 7-segment reader: stabilises {seg_n, an_n} samples and decodes them to per-digit nibbles.
// Optional decimal-point capture enabled by defining SEG7_CAPTURE_DP_EN.
module seg7_capture #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
`ifdef SEG7_CAPTURE_DP_EN
  input  logic                  seg_dp_n,
  output logic [DIGITS-1:0]     digit_dp,
`endif
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  update,
  output logic [2:0]            update_idx,
  output logic                  err
);

  localparam int unsigned RW = 8;
`ifdef SEG7_CAPTURE_DP_EN
  localparam int unsigned SW = 8 + DIGITS;
`else
  localparam int unsigned SW = 7 + DIGITS;
`endif

  logic [SW-1:0]          pins_c;
  logic [SW-1:0]          sample_q, prev_q;
  logic [RW-1:0]          run_q, run_d;
  logic                   committed_q, committed_d;
  logic [4*DIGITS-1:0]    value_q, value_d;
  logic [DIGITS-1:0]      valid_q, valid_d;
  logic                   update_q, update_d;
  logic                   err_q, err_d;
  logic [2:0]             idx_q, idx_d;
  logic [DIGITS-1:0]      an_s_c;
  logic [6:0]             seg_s_c;
  logic [4:0]             dec_c;
  logic                   fire_c;
`ifdef SEG7_CAPTURE_DP_EN
  logic [DIGITS-1:0]      dp_q, dp_d;

  assign pins_c = {seg_dp_n, seg_n, an_n};
`else
  assign pins_c = {seg_n, an_n};
`endif

  assign an_s_c  = sample_q[DIGITS-1:0];
  assign seg_s_c = sample_q[DIGITS+6:DIGITS];

  // Active-high segment code to {ok, nibble}; unknown codes return ok=0.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'h7E:   decode = 5'h10;
      7'h30:   decode = 5'h11;
      7'h6D:   decode = 5'h12;
      7'h79:   decode = 5'h13;
      7'h33:   decode = 5'h14;
      7'h5B:   decode = 5'h15;
      7'h5F:   decode = 5'h16;
      7'h70:   decode = 5'h17;
      7'h7F:   decode = 5'h18;
      7'h7B:   decode = 5'h19;
      7'h77:   decode = 5'h1A;
      7'h1F:   decode = 5'h1B;
      7'h4E:   decode = 5'h1C;
      7'h3D:   decode = 5'h1D;
      7'h4F:   decode = 5'h1E;
      7'h47:   decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  assign dec_c = decode(~seg_s_c);

  // Run tracking on registered samples, then one commit per stable run.
  always_comb begin
    run_d       = run_q;
    committed_d = committed_q;
    value_d     = value_q;
    valid_d     = valid_q;
    update_d    = 1'b0;
    err_d       = 1'b0;
    idx_d       = idx_q;
    fire_c      = 1'b0;
`ifdef SEG7_CAPTURE_DP_EN
    dp_d        = dp_q;
`endif

    if (sample_q != prev_q) begin
      run_d       = RW'(1);
      committed_d = 1'b0;
    end else if (run_q < RW'(STABLE_CYCLES)) begin
      run_d = run_q + RW'(1);
    end

    fire_c = (run_d == RW'(STABLE_CYCLES)) && !committed_d;

    if (fire_c) begin
      committed_d = 1'b1;
      if ($onehot(~an_s_c)) begin
        for (int i = 0; i < DIGITS; i++) begin
          if (!an_s_c[i]) begin
            idx_d = 3'(i);
            if (dec_c[4]) begin
              value_d[4*i +: 4] = dec_c[3:0];
              valid_d[i]        = 1'b1;
              update_d          = 1'b1;
`ifdef SEG7_CAPTURE_DP_EN
              dp_d[i]           = ~sample_q[SW-1];
`endif
            end else begin
              valid_d[i] = 1'b0;
              err_d      = 1'b1;
            end
          end
        end
      end else if (!(&an_s_c)) begin
        // Several digits selected at once: flag it, touch no storage.
        err_d = 1'b1;
        idx_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q    <= '1;
      prev_q      <= '1;
      run_q       <= '0;
      committed_q <= 1'b0;
      value_q     <= '0;
      valid_q     <= '0;
      update_q    <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= 3'd0;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q        <= '0;
`endif
    end else begin
      sample_q    <= pins_c;
      prev_q      <= sample_q;
      run_q       <= run_d;
      committed_q <= committed_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      update_q    <= update_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
`ifdef SEG7_CAPTURE_DP_EN
      dp_q        <= dp_d;
`endif
    end
  end

  assign value       = value_q;
  assign digit_valid = valid_q;
  assign update      = update_q;
  assign err         = err_q;
  assign update_idx  = idx_q;
`ifdef SEG7_CAPTURE_DP_EN
  assign digit_dp    = dp_q;
`endif

endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: vector table drives held patterns, expected commits are queued and matched on pulses.
module tb_seg7_capture;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned S      = 4;
  localparam logic [6:0] SEG_HI [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                         7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  typedef enum int {K_NONE = 0, K_UPD = 1, K_ERR = 2} kind_e;

  typedef struct {
    logic [6:0] seg_n;
    logic [3:0] an_n;
    int         n;
    kind_e      kind;
    int         idx;
    logic [3:0] nib;
  } vec_t;

  typedef struct {
    kind_e      kind;
    int         idx;
    logic [15:0] val;
    logic [3:0] vld;
    int         due;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_n = '1;
  logic [3:0]  an_n = '1;
  logic [15:0] value;
  logic [3:0]  digit_valid;
  logic        update;
  logic [2:0]  update_idx;
  logic        err;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         q[$];
  ev_t         mon_e;
  logic [15:0] m_val = '0;
  logic [3:0]  m_vld = '0;
  vec_t        vecs[$];

  seg7_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .seg_n      (seg_n),
    .an_n       (an_n),
    .value      (value),
    .digit_valid(digit_valid),
    .update     (update),
    .update_idx (update_idx),
    .err        (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] s, input logic [3:0] a, input int n,
                              input kind_e k, input int idx, input logic [3:0] nib);
    vec_t v;
    v.seg_n = s; v.an_n = a; v.n = n; v.kind = k; v.idx = idx; v.nib = nib;
    return v;
  endfunction

  // Drive one held pattern; queue the commit it must produce, if any.
  task automatic apply(input vec_t v);
    ev_t e;
    seg_n = v.seg_n;
    an_n  = v.an_n;
    if (v.kind != K_NONE) begin
      if (v.kind == K_UPD) begin
        m_val[4*v.idx +: 4] = v.nib;
        m_vld[v.idx]        = 1'b1;
      end else if ($countones(~v.an_n) == 1) begin
        m_vld[v.idx] = 1'b0;
      end
      e.kind = v.kind; e.idx = v.idx; e.val = m_val; e.vld = m_vld;
      e.due  = cyc + 1 + S;
      q.push_back(e);
    end
    repeat (v.n) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    m_val = '0;
    m_vld = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_value"}, int'(value), 0);
    chk({tag, "_valid"}, int'(digit_valid), 0);
    chk({tag, "_update"}, int'(update), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_idx"}, int'(update_idx), 0);
  endtask

  // Every pulse must match the oldest queued commit; overdue commits count as misses.
  always @(negedge clk) begin
    if (update && err) begin
      checks++;
      errors++;
      $display("FAIL both_pulses: update and err high together at edge %0d", cyc);
    end
    if (update || err) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: update=%0b err=%0b idx=%0d at edge %0d, none expected",
                 update, err, update_idx, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("commit_edge", cyc, mon_e.due);
        chk("commit_kind", update ? 1 : 2, int'(mon_e.kind));
        chk("update_idx", int'(update_idx), mon_e.idx);
        chk("value", int'(value), int'(mon_e.val));
        chk("digit_valid", int'(digit_valid), int'(mon_e.vld));
      end
    end else if (q.size() != 0 && q[0].due < cyc) begin
      mon_e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missed_commit: no pulse by edge %0d, expected at edge %0d", cyc, mon_e.due);
    end
  end

  initial begin
    do_reset(3);
    check_idle("reset");
    apply(mk(7'h00, 4'hF, 20, K_NONE, 0, 0));
    check_idle("blank");

    vecs.push_back(mk(7'b0000110, 4'b1110, 8, K_UPD, 0, 4'h3));
    for (int i = 0; i < 16; i++)
      vecs.push_back(mk(~SEG_HI[i], 4'b1011, 6, K_UPD, 2, 4'(i)));
    vecs.push_back(mk(~SEG_HI[10], 4'b1101, 6, K_UPD, 1, 4'hA));
    vecs.push_back(mk(7'b1111110,  4'b1101, 6, K_ERR, 1, 4'h0));
    vecs.push_back(mk(~SEG_HI[1],  4'b1100, 6, K_ERR, 0, 4'h0));
    vecs.push_back(mk(~SEG_HI[1],  4'b1111, 6, K_NONE, 0, 4'h0));
    vecs.push_back(mk(~SEG_HI[15], 4'b0111, 4, K_UPD, 3, 4'hF));
    vecs.push_back(mk(~SEG_HI[8],  4'b0111, 3, K_NONE, 0, 4'h0));
    vecs.push_back(mk(~SEG_HI[1],  4'b1110, 6, K_UPD, 0, 4'h1));
    vecs.push_back(mk(~SEG_HI[7],  4'b1110, 3, K_NONE, 0, 4'h0));
    vecs.push_back(mk(~SEG_HI[1],  4'b1110, 6, K_UPD, 0, 4'h1));
    vecs.push_back(mk(~SEG_HI[5],  4'b1101, 5, K_UPD, 1, 4'h5));
    vecs.push_back(mk(~SEG_HI[1],  4'b1110, 5, K_UPD, 0, 4'h1));
    vecs.push_back(mk(~SEG_HI[5],  4'b1101, 5, K_UPD, 1, 4'h5));
    vecs.push_back(mk(7'h7F,       4'b1011, 6, K_ERR, 2, 4'h0));

    foreach (vecs[i]) apply(vecs[i]);

    // Reset part-way through a run: the pending commit is dropped, a fresh run commits.
    apply(mk(~SEG_HI[9], 4'b1011, 2, K_NONE, 0, 4'h0));
    do_reset(1);
    check_idle("midrun_reset");
    apply(mk(~SEG_HI[9], 4'b1011, 6, K_UPD, 2, 4'h9));

    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("final_value", int'(value), 16'h0900);
    chk("final_valid", int'(digit_valid), 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
Name: seg7_capture

Overview:
- Reader side of the team's multiplexed 7-segment display drive. It samples active-low segment and digit-enable lines, filters them for stability, and decodes each segment pattern back to its 4-bit hex value.
- It stores one decoded nibble per digit.
- Used as a self-check monitor on display outputs and as the decode end of board-to-board segment links.

Parameters:
- DIGITS, 4: number of multiplexed digits; legal range 1..8.
- STABLE_CYCLES, 4: number of consecutive identical samples required before a commit; legal range 1..255.

Ports:
- clk, input, 1: sole clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- seg_n, input, 7: active-low segments; bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
- an_n, input, DIGITS: active-low digit enables; bit i selects digit i.
- value, output, 4*DIGITS: decoded nibbles; digit i occupies bits [4i+3:4i].
- digit_valid, output, DIGITS: bit i set when digit i holds a good decode.
- update, output, 1: one-cycle pulse on each successful commit.
- update_idx, output, 3: digit index of the current commit; meaningful only while update or err is high.
- err, output, 1: one-cycle pulse on each failed commit.

Behaviour:
- Reset values: value=0, digit_valid=0, update=0, err=0, update_idx=0. Internal sample registers load all-ones (blank). The run counter loads 0 and the committed flag is cleared.
- Input stage: {seg_n, an_n} is registered on every edge. No other logic acts on the raw pins.
- Run counter:
  - A sample differing from the previous sample sets run=1 and clears committed.
  - An equal sample increments run, saturating at STABLE_CYCLES.
- Commit trigger: fires once per run, when run==STABLE_CYCLES and committed==0. It sets committed.
- Latency: pins stable from capture edge E0 onward -> value, digit_valid, update and err change at edge E0+STABLE_CYCLES. When STABLE_CYCLES=1, the commit occurs at E0+1.
- Commit classification, on the registered sample:
  - an_n all ones (blank): no action, no pulse.
  - Exactly one an_n bit low (index k), with a pattern in the table: value[k] gets the nibble, digit_valid[k] is set to 1, update pulses, update_idx=k.
  - Exactly one an_n bit low (index k), with a pattern not in the table: err pulses, update_idx=k, digit_valid[k] is set to 0, value[k] is held.
  - Two or more an_n bits low: err pulses, update_idx=0, and all storage is unchanged.
- Decode table, active-high segments after inverting seg_n (hex), nibble in parentheses: 7E(0) 30(1) 6D(2) 79(3) 33(4) 5B(5) 5F(6) 70(7) 7F(8) 7B(9) 77(A) 1F(B) 4E(C) 3D(D) 4F(E) 47(F). Every other code is invalid.
- update and err are never high in the same cycle, and each is high for exactly one cycle per commit.
- A held-stable input produces no repeated commits. Re-commit requires a change followed by STABLE_CYCLES stable samples.
- Glitch handling: any single-cycle change restarts the run, so glitches shorter than STABLE_CYCLES never commit.
- Rescan handling: when a display rescans the same digit after passing through other digits, each return to that digit is a new run and recommits.
- Reset mid-run: all state returns to reset values on the next edge, and any pending commit is discarded.

Optional Feature:
- Macro: SEG7_CAPTURE_DP_EN.
- Defined:
  - Adds input seg_dp_n (1 bit, active-low decimal point) and output digit_dp (DIGITS bits).
  - seg_dp_n is part of the registered sample and the stability comparison.
  - On a successful commit, digit_dp[k] gets the inverted seg_dp_n. It is cleared on reset and held on err.
- Undefined: neither port exists, and the decimal point has no effect on stability.

Test Plan:
- Reset and blank: assert rst for 3 cycles, then drive an_n=4'hF with any seg_n for 20 cycles -> all outputs 0 and no pulses.
- Decode digit 0: drive seg_n=7'b0000110, an_n=4'b1110, hold stable from edge E0 with STABLE_CYCLES=4 -> at E0+4: value[3:0]=3, digit_valid=4'b0001, update=1 for one cycle, update_idx=0. No further pulse while held.
- Full table sweep on digit 2 (an_n=4'b1011): all 16 table patterns, each held 6 cycles -> 16 update pulses, update_idx=2 on each, value[11:8] stepping 0..F.
- Invalid pattern: after A is stored on digit 1, drive seg_n=7'b1111110 with an_n=4'b1101 -> err pulse, update_idx=1, digit_valid[1]=0, value[7:4] remains A.
- Glitch and multi-select:
  - A 3-cycle glitch with STABLE_CYCLES=4 -> no commit.
  - an_n=4'b1100 held stable -> err pulse, update_idx=0, storage unchanged.
- Reset mid-run: drive a pattern stable for 2 of 4 cycles, then pulse rst -> no update. Then hold the pattern 4 cycles -> update fires.
